// File: rtl/matrix_product_sequencer_if.sv
// Handshake bundle between the operand source, the product sequencer and the
// pairwise addition stage.
interface matrix_product_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] mat_a;
    logic [11:0] mat_b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] products;

    modport master (
        output in_valid, mat_a, mat_b, out_ready,
        input  in_ready, out_valid, products
    );

    modport slave (
        input  in_valid, mat_a, mat_b, out_ready,
        output in_ready, out_valid, products
    );
endinterface

// File: rtl/matrix_product_sequencer.sv
// Computes the eight 2x2 matrix partial products with one shared 3x3 multiplier,
// one product per clock, and hands them on as a packed 48-bit vector.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// MULT  | writing P[count] each clock, P0..P7
// DONE  | products valid, waiting for out_ready
module matrix_product_sequencer (
    input  logic                        clk,
    input  logic                        rst_n,
    matrix_product_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  count;
    logic [11:0] a_reg;
    logic [11:0] b_reg;
    logic [5:0]  p_reg [8];
    logic        out_valid_r;

    logic [2:0]  a_el [4];
    logic [2:0]  b_el [4];
    logic [2:0]  op_a;
    logic [2:0]  op_b;
    logic [5:0]  prod;

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign a_el[i] = a_reg[3*i +: 3];
        assign b_el[i] = b_reg[3*i +: 3];
    end

    // P[4i+2j+k] = A[i][k] * B[k][j]: count[2]=i, count[1]=j, count[0]=k
    assign op_a = a_el[{count[2], count[0]}];
    assign op_b = b_el[{count[0], count[1]}];
    assign prod = {3'b000, op_a} * {3'b000, op_b};

    for (genvar k = 0; k < 8; k++) begin : g_pack
        assign bus.products[6*k +: 6] = p_reg[k];
    end

    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = out_valid_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= 3'd0;
            a_reg       <= 12'd0;
            b_reg       <= 12'd0;
            out_valid_r <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                p_reg[k] <= 6'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.mat_a;
                        b_reg <= bus.mat_b;
                        count <= 3'd0;
                        state <= MULT;
                    end
                end
                MULT: begin
                    p_reg[count] <= prod;
                    count        <= count + 3'd1;
                    if (count == 3'd7) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_product_sequencer.sv
// Directed and randomized checks of the matrix product sequencer against a
// matrix-level reference model.
module tb_matrix_product_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    matrix_product_sequencer_if bus ();

    matrix_product_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: C = A*B as a 2x2 matrix product, listing every term A[i][k]*B[k][j]
    // in the order P[4i+2j+k].
    function automatic logic [47:0] model(input logic [11:0] a, input logic [11:0] b);
        int am [2][2];
        int bm [2][2];
        logic [47:0] r;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                am[i][j] = int'(a[3*(2*i+j) +: 3]);
                bm[i][j] = int'(b[3*(2*i+j) +: 3]);
            end
        r = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++)
                    r[6*(4*i+2*j+k) +: 6] = 6'(am[i][k] * bm[k][j]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold = cycles of out_ready=0 in DONE, garble = disturb inputs during MULT.
    task automatic run_txn(input logic [11:0] a, input logic [11:0] b, input int hold,
                           input bit garble, output logic [47:0] got);
        logic [47:0] exp;
        exp = model(a, b);
        bus.in_valid  = 1'b1;
        bus.mat_a     = a;
        bus.mat_b     = b;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (garble) begin
                bus.mat_a    = 12'($urandom);
                bus.mat_b    = 12'($urandom);
                bus.in_valid = 1'($urandom_range(0, 1));
            end
            tick();
            chk("busy_in_ready", 48'(bus.in_ready), 48'd0);
            chk("latency_out_valid", 48'(bus.out_valid), 48'(i == 8));
        end
        bus.in_valid = 1'b0;
        got = bus.products;
        chk("products", bus.products, exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_out_valid", 48'(bus.out_valid), 48'd1);
            chk("hold_products", bus.products, exp);
            chk("hold_in_ready", 48'(bus.in_ready), 48'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("release_out_valid", 48'(bus.out_valid), 48'd0);
        chk("release_in_ready", 48'(bus.in_ready), 48'd1);
        chk("idle_products_kept", bus.products, exp);
    endtask

    initial begin
        logic [47:0] got;
        logic [11:0] a1, b1, a2, b2;
        int          acc_cyc [2];
        int          n_acc;
        logic [47:0] outq [$];

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mat_a     = '0;
        bus.mat_b     = '0;

        tick();
        tick();
        chk("rst_out_valid", 48'(bus.out_valid), 48'd0);
        chk("rst_products", bus.products, 48'd0);
        chk("rst_in_ready_low", 48'(bus.in_ready), 48'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 48'(bus.in_ready), 48'd1);

        // Basic: A=[[1,2],[3,4]], B=[[5,6],[7,7]]
        run_txn({3'd4, 3'd3, 3'd2, 3'd1}, {3'd7, 3'd7, 3'd6, 3'd5}, 0, 1'b0, got);
        chk("basic_literal", got,
            {6'd28, 6'd18, 6'd28, 6'd15, 6'd14, 6'd6, 6'd14, 6'd5});

        // All sevens
        run_txn(12'hfff, 12'hfff, 0, 1'b0, got);
        chk("max_literal", got, {8{6'b110001}});

        // Back-pressure for 20 cycles
        run_txn(12'($urandom), 12'($urandom), 20, 1'b0, got);

        // Operand isolation, then confirm no second transaction starts
        run_txn(12'($urandom), 12'($urandom), 2, 1'b1, got);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("iso_single_txn", 48'(bus.out_valid), 48'd0);
            chk("iso_idle", 48'(bus.in_ready), 48'd1);
        end

        // Reset at MULT count=4
        bus.in_valid = 1'b1;
        bus.mat_a    = 12'($urandom);
        bus.mat_b    = 12'($urandom);
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", 48'(bus.out_valid), 48'd0);
        chk("midrst_products", bus.products, 48'd0);
        chk("midrst_in_ready", 48'(bus.in_ready), 48'd1);
        run_txn({3'd1, 3'd0, 3'd0, 3'd1}, {3'd1, 3'd0, 3'd0, 3'd1}, 0, 1'b0, got);
        chk("identity_literal", got, {6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1});

        // Back-to-back with in_valid held and out_ready high
        a1 = 12'($urandom);
        b1 = 12'($urandom);
        a2 = 12'($urandom);
        b2 = 12'($urandom);
        n_acc = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.mat_a     = a1;
        bus.mat_b     = b1;
        for (int c = 0; c < 25; c++) begin
            if (bus.in_valid && bus.in_ready) begin
                if (n_acc < 2) acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (bus.out_valid && bus.out_ready) outq.push_back(bus.products);
            tick();
            if (n_acc == 1) begin
                bus.mat_a = a2;
                bus.mat_b = b2;
            end
            if (n_acc >= 2) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_accepts", 48'(n_acc), 48'd2);
        chk("b2b_spacing", 48'(acc_cyc[1] - acc_cyc[0]), 48'd10);
        chk("b2b_outputs", 48'(outq.size()), 48'd2);
        if (outq.size() == 2) begin
            chk("b2b_out0", outq[0], model(a1, b1));
            chk("b2b_out1", outq[1], model(a2, b2));
        end

        // Randomized transactions
        for (int t = 0; t < 15; t++) begin
            run_txn(12'($urandom), 12'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
